// File: rtl/zoh_decim.sv
// Multi-channel decimator: zero-order hold or power-of-two boxcar average,
// all channels driven from one shared timebase.
module zoh_decim #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DIV_W    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [DIV_W-1:0]          div_ratio,
  input  logic [3:0]                avg_shift,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic                      tick,
  output logic [DIV_W+7:0]          phase
);

  localparam int PW = DIV_W + 8;
  // 15 guard bits cover 2^15 full-scale samples without overflow
  localparam int AW = WIDTH + 15;

  // Terminal phase value (N-1) for a period configuration
  function automatic logic [PW-1:0] period_last(input logic m,
                                                input logic [DIV_W-1:0] dv,
                                                input logic [3:0] sh);
    logic [31:0] n;
    if (m) begin
      n = 32'd1 << sh;
    end else if (dv == {DIV_W{1'b0}}) begin
      n = 32'd1;
    end else begin
      n = 32'(dv);
    end
    return PW'(n - 32'd1);
  endfunction

  logic                      mode_q,  mode_d;
  logic [PW-1:0]             last_q,  last_d;
  logic [3:0]                shift_q, shift_d;
  logic [PW-1:0]             phase_q, phase_d;
  logic                      tick_q,  tick_d;
  logic [CHANNELS*WIDTH-1:0] dout_q,  dout_d;
  logic signed [AW-1:0]      acc_q [CHANNELS];
  logic signed [AW-1:0]      acc_d [CHANNELS];
  logic signed [AW-1:0]      sum_s [CHANNELS];
  logic signed [AW-1:0]      avg_s [CHANNELS];
  logic                      boundary_s;

  // Next-state: timebase, config reload, accumulate and output update
  always_comb begin
    mode_d     = mode_q;
    last_d     = last_q;
    shift_d    = shift_q;
    phase_d    = phase_q;
    tick_d     = 1'b0;
    dout_d     = dout_q;
    boundary_s = enable && (phase_q == last_q);
    for (int k = 0; k < CHANNELS; k++) begin
      acc_d[k] = acc_q[k];
      sum_s[k] = acc_q[k] + AW'($signed(din[k*WIDTH +: WIDTH]));
      avg_s[k] = sum_s[k] >>> shift_q;
    end
    if (boundary_s) begin
      phase_d = {PW{1'b0}};
      tick_d  = 1'b1;
      mode_d  = mode;
      last_d  = period_last(mode, div_ratio, avg_shift);
      shift_d = avg_shift;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_d[k] = {AW{1'b0}};
        if (mode_q) begin
          dout_d[k*WIDTH +: WIDTH] = avg_s[k][WIDTH-1:0];
        end else begin
          dout_d[k*WIDTH +: WIDTH] = din[k*WIDTH +: WIDTH];
        end
      end
    end else if (enable) begin
      phase_d = phase_q + PW'(1);
      for (int k = 0; k < CHANNELS; k++) begin
        if (mode_q) begin
          acc_d[k] = sum_s[k];
        end else begin
          acc_d[k] = {AW{1'b0}};
        end
      end
    end else begin
      phase_d = phase_q;
    end
  end

  // State registers; reset discards the period and samples the config inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= mode;
      last_q  <= period_last(mode, div_ratio, avg_shift);
      shift_q <= avg_shift;
      phase_q <= {PW{1'b0}};
      tick_q  <= 1'b0;
      dout_q  <= {(CHANNELS*WIDTH){1'b0}};
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= {AW{1'b0}};
      end
    end else begin
      mode_q  <= mode_d;
      last_q  <= last_d;
      shift_q <= shift_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      dout_q  <= dout_d;
      for (int k = 0; k < CHANNELS; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  assign dout  = dout_q;
  assign tick  = tick_q;
  assign phase = phase_q;

endmodule
